// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains an 8-bit FIFO one byte at a time.
// Frame: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// All outputs are registered so the serial line is glitch-free.
module uart_tx_fifo_drain #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] BaudPenult = CntW'(CLKS_PER_BIT - 2);
  localparam logic [CntW-1:0] BaudOne    = CntW'(1);
  localparam logic [2:0]      StopLast   = 3'(STOP_BITS - 1);
  localparam logic            ParEn      = 1'(PARITY != 0);
  localparam logic            ParOdd     = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic            fifo_rd_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic            bit_end;

  assign bit_end = (baud_q == BaudLast);

  assign fifo_rd = fifo_rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Frame sequencer: state, baud/bit counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      fifo_rd_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fifo_rd_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // fifo_empty is only looked at here, so a pop never underflows.
          if (en && !fifo_empty) begin
            state_q   <= StRead;
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StRead: begin
          state_q <= StLoad;
        end
        StLoad: begin
          shift_q <= fifo_data;
          par_q   <= (^fifo_data) ^ ParOdd;
          state_q <= StStart;
          tx_q    <= 1'b0;
          baud_q  <= '0;
        end
        StStart: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              if (ParEn) begin
                state_q <= StParity;
                tx_q    <= par_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
                bit_q   <= '0;
              end
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              // Next data bit is the one about to land in shift[0].
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end
        StParity: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == StopLast) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BaudOne;
            // Raise done one edge early so it lines up with the final stop cycle.
            if (baud_q == BaudPenult && bit_q == StopLast) begin
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (no/even/odd parity, 1/1/2 stop bits)
// drain the same byte stream; a per-cycle frame model predicts every output.
module tb_uart_tx_fifo_drain;

  localparam int Clks = 4;

  logic clk;
  logic rst_n;
  logic en;

  logic [7:0] stim [256];
  int         stim_len = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar l = 0; l < 3; l++) begin : g_lane
    localparam int unsigned Par  = l;
    localparam int unsigned Stop = (l == 2) ? 2 : 1;
    localparam int FrameLen = 2 + (9 + ((Par != 0) ? 1 : 0) + Stop) * Clks;

    logic       rd;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] fdata;
    logic       empty;
    int         rd_ptr = 0;

    assign empty = (rd_ptr >= stim_len);

    uart_tx_fifo_drain #(
      .CLKS_PER_BIT(Clks),
      .PARITY      (Par),
      .STOP_BITS   (Stop)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .fifo_empty(empty),
      .fifo_data (fdata),
      .fifo_rd   (rd),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
    );

    // FIFO read side: registered data one cycle after the pop, junk otherwise.
    always @(posedge clk) begin
      if (rd) begin
        fdata  <= stim[8'(rd_ptr)];
        rd_ptr <= rd_ptr + 1;
      end else begin
        fdata <= 8'($urandom);
      end
    end

    // Frame model: t = cycles since the pop cycle, -1 when idle.
    int         t = -1;
    int         npop = 0;
    int         n_rd = 0;
    int         n_done = 0;
    logic [7:0] cur = 8'h00;
    logic       rst_seen = 1'b0;
    logic       en_seen = 1'b0;
    logic       empty_seen = 1'b1;

    initial begin
      int   b;
      logic bitv;
      logic [3:0] exp_v;
      forever begin
        @(negedge clk);
        if (!rst_seen) begin
          t = -1;
        end else if (t < 0) begin
          if (en_seen && !empty_seen) begin
            t   = 0;
            cur = stim[8'(npop)];
            npop++;
          end
        end else begin
          t++;
          if (t == FrameLen) t = -1;
        end
        // expected {fifo_rd, busy, done, tx}
        if (t < 0) begin
          exp_v = 4'b0001;
        end else if (t == 0) begin
          exp_v = 4'b1101;
        end else if (t == 1) begin
          exp_v = 4'b0101;
        end else begin
          b = (t - 2) / Clks;
          if (b == 0) bitv = 1'b0;
          else if (b <= 8) bitv = cur[b-1];
          else if (Par != 0 && b == 9) bitv = (^cur) ^ (Par == 2);
          else bitv = 1'b1;
          exp_v = {1'b0, 1'b1, (t == FrameLen - 1), bitv};
        end
        check($sformatf("lane%0d_out_t%0d", l, t), 32'({rd, busy, done, tx}), 32'(exp_v));
        if (rd === 1'b1) n_rd++;
        if (done === 1'b1) n_done++;
        rst_seen   = rst_n;
        en_seen    = en;
        empty_seen = empty;
      end
    end
  end

  int base_rd [3];
  int base_done [3];

  function automatic int lane_rd(input int i);
    case (i)
      0:       return g_lane[0].n_rd;
      1:       return g_lane[1].n_rd;
      default: return g_lane[2].n_rd;
    endcase
  endfunction

  function automatic int lane_done(input int i);
    case (i)
      0:       return g_lane[0].n_done;
      1:       return g_lane[1].n_done;
      default: return g_lane[2].n_done;
    endcase
  endfunction

  function automatic logic [1:0] lane_tx_busy(input int i);
    case (i)
      0:       return {g_lane[0].tx, g_lane[0].busy};
      1:       return {g_lane[1].tx, g_lane[1].busy};
      default: return {g_lane[2].tx, g_lane[2].busy};
    endcase
  endfunction

  function automatic bit all_idle();
    return g_lane[0].t < 0 && g_lane[1].t < 0 && g_lane[2].t < 0 &&
           g_lane[0].rd_ptr == stim_len && g_lane[1].rd_ptr == stim_len &&
           g_lane[2].rd_ptr == stim_len;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    stim[8'(stim_len)] = b;
    stim_len++;
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      base_rd[i]   = lane_rd(i);
      base_done[i] = lane_done(i);
    end
  endtask

  task automatic check_counts(input string tag, input int exp_rd, input int exp_done);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_lane%0d_rd_pulses", tag, i), 32'(lane_rd(i) - base_rd[i]),
            32'(exp_rd));
      check($sformatf("%s_lane%0d_done_pulses", tag, i), 32'(lane_done(i) - base_done[i]),
            32'(exp_done));
    end
  endtask

  task automatic wait_drained(input int budget, input string tag);
    int n = 0;
    while (!all_idle() && n < budget) begin
      cyc(1);
      n++;
    end
    check({tag, "_drained"}, 32'(all_idle()), 32'd1);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    en    = 1'b1;
    push(8'hA5);
    snap();
    cyc(2);
    rst_n = 1'b1;
    wait_drained(300, "a5");
    check_counts("a5", 1, 1);

    // 0x01 gives the opposite parity bit to 0xA5
    snap();
    push(8'h01);
    wait_drained(300, "b01");
    check_counts("b01", 1, 1);

    // Preloaded burst drains back to back
    snap();
    en = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    cyc(3);
    en = 1'b1;
    wait_drained(2000, "burst");
    check_counts("burst", 16, 16);

    // en dropped mid-frame: frame completes, nothing further popped
    snap();
    push(8'h3C);
    push(8'h77);
    cyc(20);
    en = 1'b0;
    cyc(80);
    check_counts("en_low", 1, 1);
    snap();
    en = 1'b1;
    wait_drained(300, "en_resume");
    check_counts("en_resume", 1, 1);

    // Reset pulse during data bit 3
    snap();
    for (int i = 0; i < 3; i++) push(8'($urandom));
    n = 0;
    while (!(g_lane[0].t >= 18 && g_lane[0].t <= 20) && n < 200) begin
      cyc(1);
      n++;
    end
    check("rst_window_found", 32'(n < 200), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_lane%0d_tx_busy", i), 32'(lane_tx_busy(i)), 32'b10);
    end
    rst_n = 1'b1;
    wait_drained(600, "post_rst");
    check_counts("post_rst", 3, 2);

    // Random traffic with random enable gating
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push(8'($urandom));
      en = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(5, 60));
    end
    en = 1'b1;
    wait_drained(4000, "random");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("total_lane%0d_rd", i), 32'(lane_rd(i)), 32'(stim_len));
      // exactly one byte was lost to the mid-frame reset
      check($sformatf("total_lane%0d_done", i), 32'(lane_done(i)), 32'(stim_len - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
